// File: rtl/ram_loader.sv
// ram_loader: boot-time loader that takes a framed byte stream (LEN, payload,
// CHK) and writes little-endian 32-bit words into RAM starting at BASE_ADDR.
// The frame checksum is compared against the sum of the written words.
// Optional feature macro: RAM_LOADER_VERIFY_EN adds a readback pass
// (VERIFY/VWAIT) whose sum must also match CHK before done is raised.
module ram_loader #(
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter int          DEPTH_WORDS = 2048
) (
    input  logic        clk_cpu,
    input  logic        resetn,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        ram_sel,
    output logic [3:0]  ram_wen,
    output logic [15:0] ram_address,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [13:0] word_count
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LEN0   = 4'd1,
        S_LEN1   = 4'd2,
        S_DATA   = 4'd3,
        S_WRITE  = 4'd4,
        S_TRAIL  = 4'd5,
        S_VERIFY = 4'd6,
        S_VWAIT  = 4'd7,
        S_FIN    = 4'd8
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [13:0] len_q, len_d;
    logic [31:0] word_q, word_d;
    logic [31:0] chk_q, chk_d;
    logic [31:0] wsum_q, wsum_d;
    logic [13:0] word_count_q, word_count_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        busy_q, busy_d;
    logic        in_ready_q, in_ready_d;
    logic        ram_sel_q, ram_sel_d;
    logic [3:0]  ram_wen_q, ram_wen_d;
    logic [15:0] ram_address_q, ram_address_d;
    logic [31:0] ram_wdata_q, ram_wdata_d;

    logic        accept_s;
    logic [15:0] len_full_s;
    logic [31:0] chk_full_s;

`ifdef RAM_LOADER_VERIFY_EN
    logic [31:0] rsum_q, rsum_d;
    logic [13:0] vidx_q, vidx_d;
    logic [31:0] rsum_full_s;
    assign rsum_full_s = rsum_q + ram_rdata;
`else
    // Readback data is only consumed by the verify pass.
    logic unused_rdata_s;
    assign unused_rdata_s = ^ram_rdata;
`endif

    assign accept_s   = in_valid & in_ready_q;
    assign len_full_s = {in_data, len_q[7:0]};
    assign chk_full_s = {in_data, chk_q[23:0]};

    assign in_ready    = in_ready_q;
    assign ram_sel     = ram_sel_q;
    assign ram_wen     = ram_wen_q;
    assign ram_address = ram_address_q;
    assign ram_wdata   = ram_wdata_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign word_count  = word_count_q;

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk_cpu or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            byte_idx_q    <= 2'd0;
            len_q         <= 14'd0;
            word_q        <= 32'd0;
            chk_q         <= 32'd0;
            wsum_q        <= 32'd0;
            word_count_q  <= 14'd0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            busy_q        <= 1'b0;
            in_ready_q    <= 1'b0;
            ram_sel_q     <= 1'b0;
            ram_wen_q     <= 4'h0;
            ram_address_q <= BASE_ADDR;
            ram_wdata_q   <= 32'd0;
`ifdef RAM_LOADER_VERIFY_EN
            rsum_q        <= 32'd0;
            vidx_q        <= 14'd0;
`endif
        end else begin
            state_q       <= state_d;
            byte_idx_q    <= byte_idx_d;
            len_q         <= len_d;
            word_q        <= word_d;
            chk_q         <= chk_d;
            wsum_q        <= wsum_d;
            word_count_q  <= word_count_d;
            done_q        <= done_d;
            error_q       <= error_d;
            busy_q        <= busy_d;
            in_ready_q    <= in_ready_d;
            ram_sel_q     <= ram_sel_d;
            ram_wen_q     <= ram_wen_d;
            ram_address_q <= ram_address_d;
            ram_wdata_q   <= ram_wdata_d;
`ifdef RAM_LOADER_VERIFY_EN
            rsum_q        <= rsum_d;
            vidx_q        <= vidx_d;
`endif
        end
    end

    // Next-state and datapath update: frame parsing, packing and sums.
    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        len_d        = len_q;
        word_d       = word_q;
        chk_d        = chk_q;
        wsum_d       = wsum_q;
        word_count_d = word_count_q;
        done_d       = done_q;
        error_d      = error_q;
`ifdef RAM_LOADER_VERIFY_EN
        rsum_d       = rsum_q;
        vidx_d       = vidx_q;
`endif
        case (state_q)
            S_IDLE, S_FIN: begin
                if (start) begin
                    state_d      = S_LEN0;
                    done_d       = 1'b0;
                    error_d      = 1'b0;
                    word_count_d = 14'd0;
                    byte_idx_d   = 2'd0;
                    wsum_d       = 32'd0;
`ifdef RAM_LOADER_VERIFY_EN
                    rsum_d       = 32'd0;
`endif
                end else begin
                    state_d = state_q;
                end
            end
            S_LEN0: begin
                if (accept_s) begin
                    len_d   = {6'd0, in_data};
                    state_d = S_LEN1;
                end else begin
                    state_d = S_LEN0;
                end
            end
            S_LEN1: begin
                if (accept_s) begin
                    len_d      = len_full_s[13:0];
                    byte_idx_d = 2'd0;
                    if (len_full_s > 16'(DEPTH_WORDS)) begin
                        state_d = S_FIN;
                        error_d = 1'b1;
                    end else if (len_full_s == 16'd0) begin
                        state_d = S_TRAIL;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_LEN1;
                end
            end
            S_DATA: begin
                if (accept_s) begin
                    word_d[{byte_idx_q, 3'b000} +: 8] = in_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_WRITE: begin
                wsum_d       = wsum_q + ram_wdata_q;
                word_count_d = word_count_q + 14'd1;
                if ((word_count_q + 14'd1) == len_q) begin
                    state_d = S_TRAIL;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_TRAIL: begin
                if (accept_s) begin
                    chk_d[{byte_idx_q, 3'b000} +: 8] = in_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q != 2'd3) begin
                        state_d = S_TRAIL;
                    end else if (chk_full_s != wsum_q) begin
                        state_d = S_FIN;
                        error_d = 1'b1;
`ifdef RAM_LOADER_VERIFY_EN
                    end else if (len_q != 14'd0) begin
                        state_d = S_VERIFY;
                        vidx_d  = 14'd0;
`endif
                    end else begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = S_TRAIL;
                end
            end
`ifdef RAM_LOADER_VERIFY_EN
            S_VERIFY: begin
                // Data for the read issued last cycle arrives now.
                if (vidx_q != 14'd0) begin
                    rsum_d = rsum_full_s;
                end else begin
                    rsum_d = rsum_q;
                end
                if (vidx_q == (len_q - 14'd1)) begin
                    state_d = S_VWAIT;
                end else begin
                    vidx_d  = vidx_q + 14'd1;
                    state_d = S_VERIFY;
                end
            end
            S_VWAIT: begin
                rsum_d  = rsum_full_s;
                state_d = S_FIN;
                if (rsum_full_s == chk_q) begin
                    done_d = 1'b1;
                end else begin
                    error_d = 1'b1;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered output values derived from the state being entered.
    always_comb begin
        in_ready_d    = (state_d == S_LEN0) || (state_d == S_LEN1) ||
                        (state_d == S_DATA) || (state_d == S_TRAIL);
        busy_d        = (state_d != S_IDLE) && (state_d != S_FIN);
        ram_sel_d     = 1'b0;
        ram_wen_d     = 4'h0;
        ram_address_d = ram_address_q;
        ram_wdata_d   = ram_wdata_q;
        if (state_d == S_WRITE) begin
            ram_sel_d     = 1'b1;
            ram_wen_d     = 4'hF;
            ram_address_d = BASE_ADDR + {word_count_q, 2'b00};
            ram_wdata_d   = word_d;
`ifdef RAM_LOADER_VERIFY_EN
        end else if (state_d == S_VERIFY) begin
            ram_sel_d     = 1'b1;
            ram_wen_d     = 4'h0;
            ram_address_d = BASE_ADDR + {vidx_d, 2'b00};
`endif
        end else begin
            ram_sel_d     = 1'b0;
            ram_wen_d     = 4'h0;
        end
    end

endmodule

// File: tb/tb_ram_loader.sv
// Scoreboard bench for ram_loader: expected bus cycles are queued by the
// stimulus and popped by an independent bus monitor.
module tb_ram_loader;

    logic        clk_cpu = 1'b0;
    logic        resetn  = 1'b0;
    logic        start   = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        ram_sel;
    logic [3:0]  ram_wen;
    logic [15:0] ram_address;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = 32'd0;
    logic        busy, done, error;
    logic [13:0] word_count;

    int n_total = 0;
    int n_pass  = 0;
    logic corrupt = 1'b0;
    logic [31:0] mem [0:63];

    typedef struct {
        logic [3:0]  wen;
        logic [15:0] addr;
        logic [31:0] data;
    } bus_t;
    bus_t exp_q[$];

    ram_loader dut (
        .clk_cpu(clk_cpu), .resetn(resetn), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .ram_sel(ram_sel), .ram_wen(ram_wen), .ram_address(ram_address),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .busy(busy), .done(done), .error(error), .word_count(word_count)
    );

    always #5 clk_cpu = ~clk_cpu;

    // RAM model: word writes, registered reads, optional corruption of word 1.
    always @(posedge clk_cpu) begin
        if (ram_sel && ram_wen != 4'h0) begin
            mem[ram_address[7:2]] <= ram_wdata;
        end
        if (ram_sel && ram_wen == 4'h0) begin
            ram_rdata <= mem[ram_address[7:2]] ^
                         ((corrupt && ram_address[7:2] == 6'd1) ? 32'h0000_0100 : 32'd0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Bus monitor: every select cycle must match the head of the queue.
    always @(negedge clk_cpu) begin
        if (resetn && ram_sel) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL spurious bus cycle: addr %h wen %h", ram_address, ram_wen);
            end else begin
                bus_t e;
                e = exp_q.pop_front();
                chk("bus wen", {28'd0, ram_wen}, {28'd0, e.wen});
                chk("bus addr", {16'd0, ram_address}, {16'd0, e.addr});
                if (e.wen != 4'h0) begin
                    chk("bus wdata", ram_wdata, e.data);
                    chk("in_ready during write", {31'd0, in_ready}, 32'd0);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk_cpu);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 50) begin
            @(negedge clk_cpu);
            n++;
        end
        if (n >= 50) begin
            n_total++;
            $display("FAIL in_ready timeout: got 0 expected 1");
        end
        @(posedge clk_cpu);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] t;
            t = w >> (8 * i);
            send_byte(t[7:0]);
        end
    endtask

    task automatic send_len(input logic [15:0] l);
        send_byte(l[7:0]);
        send_byte(l[15:8]);
    endtask

    task automatic pulse_start();
        @(negedge clk_cpu);
        start = 1'b1;
        @(negedge clk_cpu);
        start = 1'b0;
    endtask

    task automatic push_bus(input logic [3:0] wen, input logic [15:0] addr, input logic [31:0] data);
        bus_t e;
        e.wen = wen; e.addr = addr; e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic push_reads(input int l);
`ifdef RAM_LOADER_VERIFY_EN
        for (int i = 0; i < l; i++) push_bus(4'h0, 16'(4 * i), 32'd0);
`else
        if (l < 0) push_bus(4'h0, 16'h0000, 32'd0);
`endif
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk_cpu);
        while (busy && n < 200) begin
            @(negedge clk_cpu);
            n++;
        end
        if (n >= 200) begin
            n_total++;
            $display("FAIL %s busy timeout: got 1 expected 0", name);
        end
        @(negedge clk_cpu);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, " in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({name, " ram_sel"}, {31'd0, ram_sel}, 32'd0);
        chk({name, " ram_wen"}, {28'd0, ram_wen}, 32'd0);
        chk({name, " ram_address"}, {16'd0, ram_address}, 32'd0);
        chk({name, " ram_wdata"}, ram_wdata, 32'd0);
        chk({name, " busy"}, {31'd0, busy}, 32'd0);
        chk({name, " done"}, {31'd0, done}, 32'd0);
        chk({name, " error"}, {31'd0, error}, 32'd0);
        chk({name, " word_count"}, {18'd0, word_count}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk_cpu);
        resetn = 1'b1;

        // L=2 frame with correct checksum.
        pulse_start();
        chk("busy after start", {31'd0, busy}, 32'd1);
        push_bus(4'hF, 16'h0000, 32'h1122_3344);
        push_bus(4'hF, 16'h0004, 32'hA5A5_A5A5);
        push_reads(2);
        send_len(16'd2);
        send_word(32'h1122_3344);
        send_word(32'hA5A5_A5A5);
        send_word(32'hB6C7_D8E9);
        wait_idle("good frame");
        chk("good done", {31'd0, done}, 32'd1);
        chk("good error", {31'd0, error}, 32'd0);
        chk("good word_count", {18'd0, word_count}, 32'd2);
        chk("good queue empty", exp_q.size(), 32'd0);

        // Same frame with a wrong checksum: no read cycles.
        pulse_start();
        chk("done cleared by start", {31'd0, done}, 32'd0);
        push_bus(4'hF, 16'h0000, 32'h1122_3344);
        push_bus(4'hF, 16'h0004, 32'hA5A5_A5A5);
        send_len(16'd2);
        send_word(32'h1122_3344);
        send_word(32'hA5A5_A5A5);
        send_word(32'h0000_0000);
        wait_idle("bad chk");
        chk("bad chk error", {31'd0, error}, 32'd1);
        chk("bad chk done", {31'd0, done}, 32'd0);
        chk("bad chk word_count", {18'd0, word_count}, 32'd2);
        chk("bad chk queue empty", exp_q.size(), 32'd0);

        // Oversize length: error right after LEN1.
        pulse_start();
        send_len(16'd2049);
        @(negedge clk_cpu);
        chk("oversize error", {31'd0, error}, 32'd1);
        chk("oversize in_ready", {31'd0, in_ready}, 32'd0);
        chk("oversize busy", {31'd0, busy}, 32'd0);
        chk("oversize done", {31'd0, done}, 32'd0);

        // Empty frame.
        pulse_start();
        send_len(16'd0);
        send_word(32'd0);
        wait_idle("empty");
        chk("empty done", {31'd0, done}, 32'd1);
        chk("empty error", {31'd0, error}, 32'd0);
        chk("empty word_count", {18'd0, word_count}, 32'd0);

`ifdef RAM_LOADER_VERIFY_EN
        // Readback mismatch caused by the RAM model.
        corrupt = 1'b1;
        pulse_start();
        push_bus(4'hF, 16'h0000, 32'h1122_3344);
        push_bus(4'hF, 16'h0004, 32'hA5A5_A5A5);
        push_reads(2);
        send_len(16'd2);
        send_word(32'h1122_3344);
        send_word(32'hA5A5_A5A5);
        send_word(32'hB6C7_D8E9);
        wait_idle("verify corrupt");
        chk("verify corrupt error", {31'd0, error}, 32'd1);
        chk("verify corrupt done", {31'd0, done}, 32'd0);
        chk("verify queue empty", exp_q.size(), 32'd0);
        corrupt = 1'b0;
`endif

        // Reset in the middle of a load, then a clean L=1 load.
        pulse_start();
        push_bus(4'hF, 16'h0000, 32'h0102_0304);
        send_len(16'd2);
        send_word(32'h0102_0304);
        send_byte(8'h55);
        @(negedge clk_cpu);
        resetn = 1'b0;
        #1;
        check_reset_outputs("mid reset");
        @(negedge clk_cpu);
        @(negedge clk_cpu);
        resetn = 1'b1;
        pulse_start();
        push_bus(4'hF, 16'h0000, 32'hDEAD_BEEF);
        push_reads(1);
        send_len(16'd1);
        send_word(32'hDEAD_BEEF);
        send_word(32'hDEAD_BEEF);
        wait_idle("after reset");
        chk("after reset done", {31'd0, done}, 32'd1);
        chk("after reset error", {31'd0, error}, 32'd0);
        chk("after reset word_count", {18'd0, word_count}, 32'd1);
        chk("after reset queue empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
